// File: rtl/multi_slave_memory_controller_pkg.sv
// Shared types and constants for the multi-slave memory controller.
//   state_t        : controller FSM states
//   DEFAULT_*      : default address map (ROM at 0, RAM at 16 MiB, 16 MiB windows)
//   onehot_decode  : hit vector to lowest-index slave number
package memory_controller_pkg;

  localparam int MAX_SLAVES = 8;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_END   = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  localparam logic [63:0] DEFAULT_ROM_BASE = 64'h0000_0000_0000_0000;
  localparam logic [63:0] DEFAULT_RAM_BASE = 64'h0000_0000_0100_0000;
  localparam logic [63:0] DEFAULT_MASK     = 64'hFFFF_FFFF_FF00_0000;

  // Scan from the top so the lowest set bit is the one left standing.
  function automatic logic [IDX_W-1:0] onehot_decode(input logic [MAX_SLAVES-1:0] hits);
    logic [IDX_W-1:0] idx;
    idx = 3'd0;
    for (int i = MAX_SLAVES - 1; i >= 0; i--) begin
      idx = hits[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_slave_memory_controller_address_decoder.sv
// Combinational address decoder.
//   address : byte address to decode
//   hit     : some slave window matches
//   index   : lowest-index matching slave (valid only with hit)
module address_decoder
  import memory_controller_pkg::*;
#(
  parameter int                            NUM_SLAVES = 2,
  parameter int                            ADDR_SIZE  = 64,
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_BASE = {DEFAULT_RAM_BASE, DEFAULT_ROM_BASE},
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_MASK = {DEFAULT_MASK, DEFAULT_MASK}
) (
  input  logic [ADDR_SIZE-1:0] address,
  output logic                 hit,
  output logic [IDX_W-1:0]     index
);

  logic [MAX_SLAVES-1:0] w_hits;

  // Per-slave window match, padded to the full eight-entry vector.
  always_comb begin
    w_hits = 8'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hits[i] = ((address & SLAVE_MASK[i*ADDR_SIZE +: ADDR_SIZE]) ==
                   SLAVE_BASE[i*ADDR_SIZE +: ADDR_SIZE]);
    end
  end

  assign hit   = |w_hits;
  assign index = onehot_decode(w_hits);

endmodule

// File: rtl/multi_slave_memory_controller.sv
// Registered bus controller: one CPU memory port to NUM_SLAVES busy-pulse slaves.
//   clock/reset          : clock, asynchronous active-low reset
//   transfer_*           : CPU request (enable level) and status (busy/done/error)
//   byte_write_enable    : nonzero = write lanes, zero = read
//   write_data/mem_address/read_data : CPU payload, address, registered read result
//   slave_*              : broadcast address/data/lanes, one-hot selects, per-slave busy/data
module multi_slave_memory_controller
  import memory_controller_pkg::*;
#(
  parameter int                              NUM_SLAVES     = 2,
  parameter int                              ADDR_SIZE      = 64,
  parameter int                              DATA_SIZE      = 64,
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_BASE     = {DEFAULT_RAM_BASE, DEFAULT_ROM_BASE},
  parameter logic [NUM_SLAVES*ADDR_SIZE-1:0] SLAVE_MASK     = {DEFAULT_MASK, DEFAULT_MASK},
  parameter int                              TIMEOUT_CYCLES = 255,
  localparam int                             BYTES          = DATA_SIZE / 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            transfer_enable,
  input  logic [BYTES-1:0]                byte_write_enable,
  input  logic [DATA_SIZE-1:0]            write_data,
  input  logic [ADDR_SIZE-1:0]            mem_address,
  output logic [DATA_SIZE-1:0]            read_data,
  output logic                            transfer_busy,
  output logic                            transfer_done,
  output logic                            transfer_error,
  output logic [ADDR_SIZE-1:0]            slave_address,
  output logic [DATA_SIZE-1:0]            slave_write_data,
  output logic [BYTES-1:0]                slave_byte_write_enable,
  output logic                            slave_output_enable,
  output logic [NUM_SLAVES-1:0]           slave_chip_select,
  input  logic [NUM_SLAVES*DATA_SIZE-1:0] slave_read_data,
  input  logic [NUM_SLAVES-1:0]           slave_busy
);

  localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t                r_state, w_state_next;
  logic [ADDR_SIZE-1:0]  r_addr;
  logic [DATA_SIZE-1:0]  r_wdata, r_rdata, w_sel_rdata;
  logic [BYTES-1:0]      r_lanes;
  logic [IDX_W-1:0]      r_index, w_dec_index;
  logic [CNT_W-1:0]      r_count, w_count_inc;
  logic                  r_done, r_error;
  logic                  w_hit, w_sel_busy, w_complete, w_timeout, w_active;

  address_decoder #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_SIZE(ADDR_SIZE),
    .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_address_decoder (
    .address(mem_address), .hit(w_hit), .index(w_dec_index)
  );

  // Read mux: only the latched slave's busy and data are ever looked at.
  always_comb begin
    w_sel_busy  = 1'b0;
    w_sel_rdata = {DATA_SIZE{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_sel_busy  = (r_index == IDX_W'(i)) ? slave_busy[i] : w_sel_busy;
      w_sel_rdata = (r_index == IDX_W'(i)) ? slave_read_data[i*DATA_SIZE +: DATA_SIZE] : w_sel_rdata;
    end
  end

  assign w_count_inc = r_count + CNT_W'(1);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a busy fall in WAIT_END beats a coincident timeout.
  always_comb begin
    w_state_next = r_state;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (transfer_enable) w_state_next = w_hit ? ST_WAIT_START : ST_DONE;
        else                 w_state_next = ST_IDLE;
      end
      ST_WAIT_START: begin
        if (w_sel_busy) begin
          w_state_next = ST_WAIT_END;
        end else if (w_count_inc == TMO_LIMIT) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end else begin
          w_state_next = ST_WAIT_START;
        end
      end
      ST_WAIT_END: begin
        if (!w_sel_busy) begin
          w_state_next = ST_DONE;
          w_complete   = 1'b1;
        end else if (w_count_inc == TMO_LIMIT) begin
          w_state_next = ST_DONE;
          w_timeout    = 1'b1;
        end else begin
          w_state_next = ST_WAIT_END;
        end
      end
      ST_DONE: begin
        if (transfer_enable) w_state_next = ST_DONE;
        else                 w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Request latches, cycle counter, read data capture, done pulse and error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= {ADDR_SIZE{1'b0}};
      r_wdata <= {DATA_SIZE{1'b0}};
      r_lanes <= {BYTES{1'b0}};
      r_index <= 3'd0;
      r_count <= {CNT_W{1'b0}};
      r_rdata <= {DATA_SIZE{1'b0}};
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done <= (w_state_next == ST_DONE) && (r_state != ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (transfer_enable) begin
            r_addr  <= mem_address;
            r_wdata <= write_data;
            r_lanes <= byte_write_enable;
            r_index <= w_dec_index;
            r_count <= {CNT_W{1'b0}};
            if (!w_hit) begin
              r_error <= 1'b1;
              r_rdata <= {DATA_SIZE{1'b0}};
            end
          end
        end
        ST_WAIT_START, ST_WAIT_END: begin
          r_count <= w_count_inc;
          if (w_complete && (r_lanes == {BYTES{1'b0}})) r_rdata <= w_sel_rdata;
          if (w_timeout) r_error <= 1'b1;
        end
        ST_DONE: begin
          if (!transfer_enable) r_error <= 1'b0;
        end
        default: r_error <= 1'b0;
      endcase
    end
  end

  // Output decode from registered state and latches.
  always_comb begin
    w_active = (r_state == ST_WAIT_START) || (r_state == ST_WAIT_END);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slave_chip_select[i] = w_active && (r_index == IDX_W'(i));
    end
    slave_byte_write_enable = w_active ? r_lanes : {BYTES{1'b0}};
    slave_output_enable     = w_active && (r_lanes == {BYTES{1'b0}});
  end

  assign transfer_busy    = w_active;
  assign transfer_done    = r_done;
  assign transfer_error   = r_error;
  assign read_data        = r_rdata;
  assign slave_address    = r_addr;
  assign slave_write_data = r_wdata;

endmodule

// File: tb/tb_multi_slave_memory_controller.sv
module tb_multi_slave_memory_controller;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [7:0]   bwe = 8'd0;
  logic [63:0]  wdata = 64'd0;
  logic [63:0]  addr = 64'd0;
  logic [63:0]  rdata;
  logic         busy, done, err;
  logic [63:0]  s_addr, s_wdata;
  logic [7:0]   s_bwe;
  logic         s_oe;
  logic [1:0]   s_cs;
  logic [127:0] s_rdata;
  logic [1:0]   s_busy;

  always #5 clk = ~clk;

  multi_slave_memory_controller #(.TIMEOUT_CYCLES(20)) dut (
    .clock(clk), .reset(rst_n), .transfer_enable(en), .byte_write_enable(bwe),
    .write_data(wdata), .mem_address(addr), .read_data(rdata),
    .transfer_busy(busy), .transfer_done(done), .transfer_error(err),
    .slave_address(s_addr), .slave_write_data(s_wdata),
    .slave_byte_write_enable(s_bwe), .slave_output_enable(s_oe),
    .slave_chip_select(s_cs), .slave_read_data(s_rdata), .slave_busy(s_busy));

  // Slave models: slave 0 is a ROM returning DEAD_BEEF_0000_<word>, slave 1 a 16-word RAM.
  logic [63:0] ram [16];
  int          shold [2];
  int          scnt [2];
  logic        sfin [2];

  assign s_rdata[63:0]   = 64'hDEAD_BEEF_0000_0000 | {60'd0, s_addr[6:3]};
  assign s_rdata[127:64] = ram[s_addr[6:3]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!s_cs[k]) begin
        s_busy[k] <= 1'b0; scnt[k] <= 0; sfin[k] <= 1'b0;
      end else if (!sfin[k] && shold[k] > 0) begin
        if (scnt[k] < shold[k]) begin
          s_busy[k] <= 1'b1; scnt[k] <= scnt[k] + 1;
        end else begin
          s_busy[k] <= 1'b0; sfin[k] <= 1'b1;
          if (k == 1) begin
            for (int b = 0; b < 8; b++)
              if (s_bwe[b]) ram[s_addr[6:3]][b*8 +: 8] <= s_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Scoreboard.
  typedef struct { logic [63:0] rd; logic er; } exp_t;
  exp_t sb [$];
  int n_checks = 0, n_fail = 0, n_done = 0, n_access = 0;
  logic [1:0] cs_prev = 2'b00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: pop and compare on each completion pulse; count slave accesses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && s_cs != 2'b00 && cs_prev == 2'b00) n_access++;
    cs_prev <= s_cs;
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_done: got done with empty scoreboard expected no done");
      end else begin
        e = sb.pop_front();
        chk("read_data", rdata, e.rd);
        chk("error", {63'd0, err}, {63'd0, e.er});
        chk("cs_at_done", {62'd0, s_cs}, 64'd0);
      end
    end
  end

  // Issue one request, wait for done, optionally hold enable, then drop it for a cycle.
  task automatic xfer(input logic [63:0] a, input logic [7:0] lanes, input logic [63:0] d,
                      input logic [63:0] exp_rd, input logic exp_er, input int exp_cyc,
                      input int hold_after, output logic [1:0] cs_seen, output logic oe_seen);
    exp_t e;
    int cyc;
    e.rd = exp_rd; e.er = exp_er;
    sb.push_back(e);
    cs_seen = 2'b00; oe_seen = 1'b0; cyc = 0;
    @(posedge clk); #1;
    addr = a; bwe = lanes; wdata = d; en = 1'b1;
    @(posedge clk); #1;
    addr = ~a; wdata = ~d;  // must be ignored once accepted
    forever begin
      @(negedge clk);
      cs_seen |= s_cs; oe_seen |= s_oe;
      if (done) break;
      cyc++;
      if (cyc > 200) begin
        n_checks++; n_fail++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
        break;
      end
    end
    chk("slave_address", s_addr, a);
    chk("latency", 64'(cyc), 64'(exp_cyc));
    repeat (hold_after) @(negedge clk);
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [1:0] cs_seen;
  logic       oe_seen;
  int         acc0, done0;

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 64'd0;
    shold[0] = 12; shold[1] = 3;
    #23;
    chk("rst_read_data", rdata, 64'd0);
    chk("rst_status", {61'd0, busy, done, err}, 64'd0);
    chk("rst_cs", {62'd0, s_cs}, 64'd0);
    chk("rst_slave_addr", s_addr, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // ROM read, 12 busy cycles: done visible 14 cycles after acceptance.
    xfer(64'h18, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0003, 1'b0, 14, 0, cs_seen, oe_seen);
    chk("rom_cs", {62'd0, cs_seen}, 64'd1);
    chk("rom_oe", {63'd0, oe_seen}, 64'd1);

    // RAM write: select slave 1 only, no output enable, read_data untouched.
    xfer(64'h0100_0008, 8'hFF, 64'd5, 64'hDEAD_BEEF_0000_0003, 1'b0, 5, 0, cs_seen, oe_seen);
    chk("wr_cs", {62'd0, cs_seen}, 64'd2);
    chk("wr_oe", {63'd0, oe_seen}, 64'd0);
    xfer(64'h0100_0008, 8'h00, 64'd0, 64'd5, 1'b0, 5, 0, cs_seen, oe_seen);

    // Unmapped: done one cycle after acceptance, no select, read_data cleared.
    xfer(64'h8000_0000, 8'h00, 64'd0, 64'd0, 1'b1, 0, 0, cs_seen, oe_seen);
    chk("unmap_cs", {62'd0, cs_seen}, 64'd0);

    // Timeout: slave 1 silent, DONE at count 20, read_data unchanged.
    shold[1] = 0;
    xfer(64'h0100_0008, 8'h00, 64'd0, 64'd0, 1'b1, 20, 0, cs_seen, oe_seen);
    chk("tmo_cs", {62'd0, cs_seen}, 64'd2);

    // Reset three cycles into a RAM read.
    shold[1] = 12;
    @(posedge clk); #1;
    addr = 64'h0100_0008; bwe = 8'h00; en = 1'b1;
    repeat (4) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_cs", {62'd0, s_cs}, 64'd0);
    chk("mid_rst_status", {61'd0, busy, done, err}, 64'd0);
    chk("mid_rst_read_data", rdata, 64'd0);
    en = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    shold[1] = 3;
    xfer(64'h0100_0008, 8'h00, 64'd0, 64'd5, 1'b0, 5, 0, cs_seen, oe_seen);

    // Enable held ten cycles past done: one access only; re-issue after a drop.
    shold[0] = 1;
    acc0 = n_access; done0 = n_done;
    xfer(64'h20, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0004, 1'b0, 3, 10, cs_seen, oe_seen);
    chk("hold_access", 64'(n_access - acc0), 64'd1);
    chk("hold_done", 64'(n_done - done0), 64'd1);
    xfer(64'h28, 8'h00, 64'd0, 64'hDEAD_BEEF_0000_0005, 1'b0, 3, 0, cs_seen, oe_seen);
    chk("reissue_access", 64'(n_access - acc0), 64'd2);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
